// File: rtl/riscv_pkg.sv
// Shared types and defaults for the branch prediction unit: branch condition
// encodings, table/counter defaults and the counter reset-value helper.
package riscv_pkg;

    typedef enum logic [2:0] {
        BRANCH_NONE = 3'd0,
        BRANCH_EQ   = 3'd1,
        BRANCH_NE   = 3'd2,
        BRANCH_LT   = 3'd3,
        BRANCH_GE   = 3'd4,
        BRANCH_LTU  = 3'd5,
        BRANCH_GEU  = 3'd6
    } branch_type_e;

    localparam int BHT_DEPTH_DEFAULT = 64;
    localparam int CTR_W_DEFAULT     = 2;

    // Weakly-not-taken: one below the taken threshold (0 for a 1-bit counter).
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter holding one prediction-table entry; resets
// asynchronously (active low) to the weakly-not-taken value.
module sat_counter
    import riscv_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] count
);

    localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_reset_val(CTR_W));
    localparam logic [CTR_W-1:0] MAX_VAL = '1;

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_VAL)) begin
            count_d = count_q + CTR_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: PC-indexed table of saturating counters, branch
// condition evaluation and registered mispredict. Optional statistics outputs
// are enabled by defining BRANCH_PRED_STATS_EN.
module branch_predict_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = BHT_DEPTH_DEFAULT,
    parameter int CTR_W     = CTR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            predict_taken,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic            resolve_pred,
    input  branch_type_e    branch_type,
    input  logic            zero_flag,
    input  logic            negative_flag,
    input  logic            carry_flag,
    input  logic            overflow_flag,
    output logic            branch_taken,
    output logic            mispredict
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic [CTR_W-1:0] ctr [BHT_DEPTH];
    logic             upd_en;
    logic             mispredict_q;
    logic             mispredict_d;

    // Instruction-aligned PCs: bits [1:0] and bits above the index never select an entry.
    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign resolve_idx = resolve_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              resolve_pc[XLEN-1:IDX_W+2], resolve_pc[1:0]};

    always_comb begin
        branch_taken = 1'b0;
        case (branch_type)
            BRANCH_EQ:  branch_taken = zero_flag;
            BRANCH_NE:  branch_taken = ~zero_flag;
            BRANCH_LT:  branch_taken = negative_flag ^ overflow_flag;
            BRANCH_GE:  branch_taken = ~(negative_flag ^ overflow_flag);
            BRANCH_LTU: branch_taken = carry_flag;
            BRANCH_GEU: branch_taken = ~carry_flag;
            default:    branch_taken = 1'b0;
        endcase
    end

    assign upd_en = resolve_valid && (branch_type != BRANCH_NONE);

    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
        logic hit;
        assign hit = upd_en && (resolve_idx == IDX_W'(gi));

        sat_counter #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (hit & branch_taken),
            .dec   (hit & ~branch_taken),
            .count (ctr[gi])
        );
    end

    // Read straight from the registered table: a same-cycle update is not bypassed.
    assign predict_taken = ctr[fetch_idx][CTR_W-1];

    assign mispredict_d = upd_en && (branch_taken != resolve_pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
        end
    end

    assign mispredict = mispredict_q;

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Mispredict count steps on the same edge that registers the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            if (upd_en) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispredict_d) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
